// File: rtl/PARAMS_pkg.sv
// Shared sizing and types for the integer register file and its pending-write scoreboard.
package PARAMS_pkg;

  localparam int unsigned WD_SIZE        = 32;
  localparam int unsigned INSTR_REG_BITS = 5;
  localparam int unsigned NUM_REGS       = 2 ** INSTR_REG_BITS;
  localparam int unsigned PEND_BITS      = 2;

  typedef logic [WD_SIZE-1:0]        word_t;
  typedef logic [INSTR_REG_BITS-1:0] reg_idx_t;
  typedef logic [PEND_BITS-1:0]      pend_cnt_t;

  localparam pend_cnt_t PendMax = '1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters with RAW hazard and saturation flags.
// REGFILE_BYPASS_EN lets a register retiring its last pending write this cycle skip the stall.
module regfile_scoreboard
  import PARAMS_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     wb_valid_i,
  input  reg_idx_t wb_rd_i,
  input  logic     issue_i,
  input  reg_idx_t issue_rd_i,
  input  reg_idx_t rs1_i,
  input  reg_idx_t rs2_i,
  output logic     hazard_o,
  output logic     pend_full_o
);

  pend_cnt_t cnt_q [NUM_REGS];
  pend_cnt_t cnt_d [NUM_REGS];

  logic rs1_pend, rs2_pend;

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      logic inc, dec;
      cnt_d[r] = cnt_q[r];
      inc = issue_i && (issue_rd_i == reg_idx_t'(r)) && (r != 0);
      dec = wb_valid_i && (wb_rd_i == reg_idx_t'(r)) && (r != 0);
      // Issue and retire to the same register cancel out; both ends saturate.
      if (inc && !dec && (cnt_q[r] != PendMax)) begin
        cnt_d[r] = cnt_q[r] + pend_cnt_t'(1);
      end else if (dec && !inc && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - pend_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    rs1_pend = (rs1_i != '0) && (cnt_q[rs1_i] != '0);
    rs2_pend = (rs2_i != '0) && (cnt_q[rs2_i] != '0);
`ifdef REGFILE_BYPASS_EN
    if (wb_valid_i && (wb_rd_i == rs1_i) && (cnt_q[rs1_i] == pend_cnt_t'(1))) rs1_pend = 1'b0;
    if (wb_valid_i && (wb_rd_i == rs2_i) && (cnt_q[rs2_i] == pend_cnt_t'(1))) rs2_pend = 1'b0;
`endif
    hazard_o    = rs1_pend || rs2_pend;
    pend_full_o = (issue_rd_i != '0) && (cnt_q[issue_rd_i] == PendMax);
  end

`ifndef SYNTHESIS
  issue_while_full_a : assert property (@(posedge clk) disable iff (!reset_n)
    !(issue_i && pend_full_o));
`endif

endmodule

// File: rtl/register_file.sv
// Architectural register file: write-back sink, two combinational read ports, RAW scoreboard.
// REGFILE_BYPASS_EN adds same-cycle write-through on the read ports.
module register_file
  import PARAMS_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     wb_valid_i,
  input  reg_idx_t wb_rd_i,
  input  word_t    wb_data_i,
  input  reg_idx_t rs1_i,
  input  reg_idx_t rs2_i,
  output word_t    rs1_data_o,
  output word_t    rs2_data_o,
  input  logic     issue_i,
  input  reg_idx_t issue_rd_i,
  output logic     hazard_o,
  output logic     pend_full_o
);

  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (wb_valid_i && (wb_rd_i != '0)) begin
      regs_d[wb_rd_i] = wb_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rs1_data_o = (rs1_i == '0) ? '0 : regs_q[rs1_i];
    rs2_data_o = (rs2_i == '0) ? '0 : regs_q[rs2_i];
`ifdef REGFILE_BYPASS_EN
    if (wb_valid_i && (wb_rd_i == rs1_i) && (rs1_i != '0)) rs1_data_o = wb_data_i;
    if (wb_valid_i && (wb_rd_i == rs2_i) && (rs2_i != '0)) rs2_data_o = wb_data_i;
`endif
  end

  regfile_scoreboard u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .wb_valid_i  (wb_valid_i),
    .wb_rd_i     (wb_rd_i),
    .issue_i     (issue_i),
    .issue_rd_i  (issue_rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .hazard_o    (hazard_o),
    .pend_full_o (pend_full_o)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios then random traffic vs. an array model.
module tb_register_file;
  import PARAMS_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic     clk = 1'b0;
  logic     reset_n;
  logic     wb_valid_i;
  reg_idx_t wb_rd_i;
  word_t    wb_data_i;
  reg_idx_t rs1_i, rs2_i;
  word_t    rs1_data_o, rs2_data_o;
  logic     issue_i;
  reg_idx_t issue_rd_i;
  logic     hazard_o, pend_full_o;

  int checks = 0;
  int errors = 0;

  // Reference state: register contents and number of outstanding writes per register.
  word_t m_regs [32];
  int    m_cnt  [32];

  register_file dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wb_valid_i  (wb_valid_i),
    .wb_rd_i     (wb_rd_i),
    .wb_data_i   (wb_data_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .rs1_data_o  (rs1_data_o),
    .rs2_data_o  (rs2_data_o),
    .issue_i     (issue_i),
    .issue_rd_i  (issue_rd_i),
    .hazard_o    (hazard_o),
    .pend_full_o (pend_full_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
  endtask

  function automatic word_t exp_read(input int idx);
    if (idx == 0) return '0;
    if (Bypass && wb_valid_i && (int'(wb_rd_i) == idx)) return wb_data_i;
    return m_regs[idx];
  endfunction

  function automatic bit exp_pending(input int idx);
    if (idx == 0 || m_cnt[idx] == 0) return 1'b0;
    if (Bypass && m_cnt[idx] == 1 && wb_valid_i && (int'(wb_rd_i) == idx)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".rs1"}, rs1_data_o, exp_read(int'(rs1_i)));
    check({tag, ".rs2"}, rs2_data_o, exp_read(int'(rs2_i)));
    check({tag, ".haz"}, 32'(hazard_o),
          32'(exp_pending(int'(rs1_i)) || exp_pending(int'(rs2_i))));
    check({tag, ".full"}, 32'(pend_full_o),
          32'((issue_rd_i != '0) && (m_cnt[int'(issue_rd_i)] == 3)));
  endtask

  // Drive one cycle, check combinational outputs before the edge, then advance the model.
  task automatic step(input string tag, input logic v, input int rd, input word_t d,
                      input int a, input int b, input logic iss, input int ird);
    int delta;
    wb_valid_i = v;  wb_rd_i = reg_idx_t'(rd); wb_data_i = d;
    rs1_i = reg_idx_t'(a); rs2_i = reg_idx_t'(b);
    issue_i = iss;   issue_rd_i = reg_idx_t'(ird);
    #2;
    check_outputs(tag);
    @(posedge clk);
    if (v && rd != 0) m_regs[rd] = d;
    for (int r = 1; r < 32; r++) begin
      delta = ((iss && ird == r) ? 1 : 0) - ((v && rd == r) ? 1 : 0);
      m_cnt[r] = m_cnt[r] + delta;
      if (m_cnt[r] < 0) m_cnt[r] = 0;
      if (m_cnt[r] > 3) m_cnt[r] = 3;
    end
    #1;
  endtask

  task automatic idle(input string tag, input int a, input int b, input int ird);
    step(tag, 1'b0, 0, '0, a, b, 1'b0, ird);
  endtask

  initial begin
    model_clear();
    reset_n = 1'b0;
    wb_valid_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    rs1_i = '0; rs2_i = '0; issue_i = 1'b0; issue_rd_i = '0;
    #12;
    for (int i = 0; i < 32; i++) begin
      rs1_i = reg_idx_t'(i); rs2_i = reg_idx_t'(31 - i); issue_rd_i = reg_idx_t'(i);
      #1;
      check("rst", rs1_data_o, '0);
      check("rst.rs2", rs2_data_o, '0);
      check("rst.haz", 32'(hazard_o), 32'd0);
      check("rst.full", 32'(pend_full_o), 32'd0);
    end
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    step("wb5", 1'b1, 5, 32'hDEAD_BEEF, 0, 0, 1'b0, 0);
    idle("rd5", 5, 0, 0);
    step("wb5_same", 1'b1, 5, 32'h1357_9BDF, 5, 5, 1'b0, 0);
    idle("rd5_new", 5, 0, 0);

    step("wb0", 1'b1, 0, 32'h1234, 0, 0, 1'b0, 0);
    step("iss0", 1'b0, 0, '0, 0, 0, 1'b1, 0);
    idle("x0_after", 0, 0, 0);

    step("iss7a", 1'b0, 0, '0, 0, 0, 1'b1, 7);
    step("iss7b", 1'b0, 0, '0, 7, 0, 1'b1, 7);
    idle("haz7_2", 7, 0, 7);
    step("wb7a", 1'b1, 7, 32'hA5A5_0007, 7, 0, 1'b0, 0);
    idle("haz7_1", 7, 0, 0);
    step("wb7b", 1'b1, 7, 32'h5A5A_0007, 0, 7, 1'b0, 0);
    idle("haz7_0", 7, 7, 0);

    step("iss9", 1'b0, 0, '0, 0, 0, 1'b1, 9);
    step("isswb9", 1'b1, 9, 32'h9999_0001, 9, 0, 1'b1, 9);
    idle("cnt9_1", 9, 0, 9);
    step("iss9b", 1'b0, 0, '0, 0, 9, 1'b1, 9);
    step("iss9c", 1'b0, 0, '0, 0, 9, 1'b1, 9);
    idle("full9", 9, 0, 9);

    // Asynchronous reset in the middle of a cycle with live state on both reg and counter paths.
    rs1_i = 5'd5; rs2_i = 5'd9; issue_rd_i = 5'd9;
    #2 reset_n = 1'b0;
    #1;
    check("arst.rs1", rs1_data_o, '0);
    check("arst.rs2", rs2_data_o, '0);
    check("arst.haz", 32'(hazard_o), 32'd0);
    check("arst.full", 32'(pend_full_o), 32'd0);
    model_clear();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    idle("post_rst", 9, 5, 9);

    for (int n = 0; n < 400; n++) begin
      int    rd, a, b, ird;
      logic  v, iss;
      word_t d;
      v   = ($urandom_range(0, 2) != 0);
      rd  = $urandom_range(0, 7);
      d   = $urandom;
      a   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      b   = $urandom_range(0, 7);
      ird = $urandom_range(0, 7);
      iss = ($urandom_range(0, 1) == 1) && (m_cnt[ird] < 3);
      step("rand", v, rd, d, a, b, iss, ird);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
